// File: rtl/input_conditioner_bank.sv
// ----------------------------------------------------------------------------
// input_conditioner_bank
//
// Multi-channel conditioner for asynchronous board inputs (buttons and
// switches). Each channel has a synchroniser chain, a debounce stability
// counter, registered rising/falling edge pulses and a toggle latch that
// flips on every accepted rising edge. Channels are fully independent: bit i
// of every vector belongs to channel i.
//
// Parameters
//   CHANNELS      number of independent channels
//   SYNC_STAGES   synchroniser depth, 2..4
//   WAIT_TIME     extra stable samples before a change is accepted,
//                 1..2^COUNTER_WIDTH-1
//   COUNTER_WIDTH width of each debounce counter
//
// Ports
//   clk           system clock, rising edge
//   reset_n       asynchronous active-low reset
//   noisy         raw asynchronous inputs
//   toggle_clr    synchronous per-channel clear of toggle_state
//   conditioned   debounced level (registered)
//   positiveedge  one-cycle pulse on an accepted 0->1
//   negativeedge  one-cycle pulse on an accepted 1->0
//   toggle_state  flips on every positiveedge of its channel
//
// The block has no handshake: every output is a registered level or a
// single-cycle pulse, valid on every clock.
// ----------------------------------------------------------------------------
module input_conditioner_bank #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int WAIT_TIME     = 3,
    parameter int COUNTER_WIDTH = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] noisy,
    input  logic [CHANNELS-1:0] toggle_clr,
    output logic [CHANNELS-1:0] conditioned,
    output logic [CHANNELS-1:0] positiveedge,
    output logic [CHANNELS-1:0] negativeedge,
    output logic [CHANNELS-1:0] toggle_state
);

    localparam logic [COUNTER_WIDTH-1:0] WAIT_CNT = COUNTER_WIDTH'(WAIT_TIME);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("input_conditioner_bank: SYNC_STAGES must be 2..4");
    end
    if (WAIT_TIME < 1 || WAIT_TIME > (2 ** COUNTER_WIDTH) - 1) begin : g_bad_wait
        $error("input_conditioner_bank: WAIT_TIME must be 1..2^COUNTER_WIDTH-1");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [SYNC_STAGES-1:0]   sync_q;
        logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
        logic                     cond_q, cond_d;
        logic                     pos_q, pos_d;
        logic                     neg_q, neg_d;
        logic                     tog_q, tog_d;
        logic                     sync_bit;

        assign sync_bit = sync_q[SYNC_STAGES-1];

        // The counter only runs while the synchronised input disagrees with
        // the accepted level; any agreeing sample (a glitch ending) drops it
        // back to zero. A change is accepted on the sample after the counter
        // has reached WAIT_TIME, so WAIT_TIME+1 disagreeing samples in a row
        // are needed and the counter never exceeds WAIT_TIME.
        always_comb begin
            cnt_d  = '0;
            cond_d = cond_q;
            pos_d  = 1'b0;
            neg_d  = 1'b0;
            if (sync_bit != cond_q) begin
                if (cnt_q == WAIT_CNT) begin
                    cond_d = sync_bit;
                    pos_d  = sync_bit;
                    neg_d  = ~sync_bit;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // Clear has priority over a flip on the same edge.
            if (toggle_clr[i]) begin
                tog_d = 1'b0;
            end else if (pos_d) begin
                tog_d = ~tog_q;
            end else begin
                tog_d = tog_q;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                sync_q <= '0;
                cnt_q  <= '0;
                cond_q <= 1'b0;
                pos_q  <= 1'b0;
                neg_q  <= 1'b0;
                tog_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], noisy[i]};
                cnt_q  <= cnt_d;
                cond_q <= cond_d;
                pos_q  <= pos_d;
                neg_q  <= neg_d;
                tog_q  <= tog_d;
            end
        end

        assign conditioned[i]  = cond_q;
        assign positiveedge[i] = pos_q;
        assign negativeedge[i] = neg_q;
        assign toggle_state[i] = tog_q;
    end

endmodule

// File: tb/tb_input_conditioner_bank.sv
// ----------------------------------------------------------------------------
// tb_input_conditioner_bank
//
// Bench for input_conditioner_bank with default parameters. A reference
// model, stepped on every rising edge, pushes the expected output vector
// into a queue; a monitor on every falling edge pops it and compares it with
// the DUT outputs. Directed scenarios add latency and toggle checks, then a
// randomized phase exercises all channels.
// ----------------------------------------------------------------------------
module tb_input_conditioner_bank;

    localparam int CH  = 4;
    localparam int SS  = 2;
    localparam int WT  = 3;
    localparam int CW  = 3;
    localparam int LAT = SS + WT + 1;

    logic          clk;
    logic          reset_n;
    logic [CH-1:0] noisy;
    logic [CH-1:0] toggle_clr;
    logic [CH-1:0] conditioned;
    logic [CH-1:0] positiveedge;
    logic [CH-1:0] negativeedge;
    logic [CH-1:0] toggle_state;

    int n_cmp = 0;
    int n_err = 0;

    input_conditioner_bank #(
        .CHANNELS     (CH),
        .SYNC_STAGES  (SS),
        .WAIT_TIME    (WT),
        .COUNTER_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .noisy       (noisy),
        .toggle_clr  (toggle_clr),
        .conditioned (conditioned),
        .positiveedge(positiveedge),
        .negativeedge(negativeedge),
        .toggle_state(toggle_state)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Synchroniser: a queue of SS past input vectors; the debouncer sees the
    // input that was applied SS edges earlier. Debounce: a change on channel
    // i is accepted when the last WT+1 seen samples all differ from the
    // accepted level and all arrived after the previous accept/reset.
    logic [CH-1:0] exp_q[$];
    logic [CH-1:0] pipe_q[$];
    logic [CH-1:0] hist_q[$];
    logic [CH-1:0] m_cond, m_pos, m_neg, m_tog, seen, h;
    int            since[CH];
    bit            acc;

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_cond = '0; m_pos = '0; m_neg = '0; m_tog = '0;
                pipe_q.delete();
                for (int k = 0; k < SS; k++) pipe_q.push_back('0);
                hist_q.delete();
                for (int i = 0; i < CH; i++) since[i] = 0;
            end else begin
                seen = pipe_q.pop_front();
                pipe_q.push_back(noisy);
                hist_q.push_back(seen);
                if (hist_q.size() > WT + 1) void'(hist_q.pop_front());
                m_pos = '0;
                m_neg = '0;
                for (int i = 0; i < CH; i++) begin
                    since[i]++;
                    acc = (since[i] >= WT + 1);
                    for (int k = 0; k < hist_q.size(); k++) begin
                        h = hist_q[k];
                        if (h[i] == m_cond[i]) acc = 0;
                    end
                    if (acc) begin
                        m_cond[i] = seen[i];
                        m_pos[i]  = seen[i];
                        m_neg[i]  = ~seen[i];
                        since[i]  = 0;
                    end
                    if (toggle_clr[i]) m_tog[i] = 1'b0;
                    else if (m_pos[i]) m_tog[i] = ~m_tog[i];
                end
            end
            exp_q.push_back(m_cond);
            exp_q.push_back(m_pos);
            exp_q.push_back(m_neg);
            exp_q.push_back(m_tog);
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [CH-1:0] e_cond, e_pos, e_neg, e_tog;
    initial begin
        forever begin
            @(negedge clk);
            n_cmp++;
            if (exp_q.size() < 4) begin
                n_err++;
                $display("FAIL scoreboard_underflow t=%0t: queue has %0d entries, required 4",
                         $time, exp_q.size());
            end else begin
                e_cond = exp_q.pop_front();
                e_pos  = exp_q.pop_front();
                e_neg  = exp_q.pop_front();
                e_tog  = exp_q.pop_front();
                if ({conditioned, positiveedge, negativeedge, toggle_state} !==
                    {e_cond, e_pos, e_neg, e_tog}) begin
                    n_err++;
                    $display("FAIL cycle_outputs t=%0t: got cond=%b pos=%b neg=%b tog=%b, expected cond=%b pos=%b neg=%b tog=%b",
                             $time, conditioned, positiveedge, negativeedge, toggle_state,
                             e_cond, e_pos, e_neg, e_tog);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change only just after a falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check(name, conditioned | positiveedge | negativeedge | toggle_state, '0);
    endtask

    // Asserts reset, confirms outputs clear without a clock edge, holds it
    // over two edges and releases it just before the next rising edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset_immediate");
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // Counts rising edges until positiveedge shows all bits of mask; returns
    // just after that edge.
    task automatic measure_latency(input string name, input logic [CH-1:0] mask);
        int n;
        bit got;
        n = 0;
        got = 0;
        while (!got && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            if ((positiveedge & mask) == mask) got = 1;
        end
        n_cmp++;
        if (!got || n != LAT) begin
            n_err++;
            $display("FAIL %s: positiveedge after %0d edges (seen=%0d), expected after %0d edges",
                     name, n, got, LAT);
        end
    endtask

    // One accepted press on channel 2, optionally clearing the toggle on the
    // edge that produces the positiveedge.
    task automatic press(input logic do_clr, input logic exp_tog);
        noisy[2] = 1'b1;
        repeat (LAT - 1) tick();
        if (do_clr) toggle_clr[2] = 1'b1;
        @(posedge clk);
        #1;
        check("toggle_pulse", {3'b000, positiveedge[2]}, 4'b0001);
        check("toggle_state", {3'b000, toggle_state[2]}, {3'b000, exp_tog});
        tick();
        toggle_clr = '0;
        noisy[2]   = 1'b0;
        repeat (LAT + 3) tick();
    endtask

    task automatic hold(input logic [CH-1:0] v, input int n);
        noisy = v;
        repeat (n) tick();
    endtask

    // ---------------- stimulus ----------------
    int hold_cnt[CH];

    initial begin
        reset_n    = 1'b0;
        noisy      = 4'b1111;
        toggle_clr = '0;

        // Reset held with inputs high: everything stays zero.
        repeat (5) tick();
        check_all_zero("reset_hold");
        reset_n = 1'b1;
        measure_latency("reset_release_latency", 4'b1111);
        check("reset_release_cond", conditioned, 4'b1111);
        check("reset_release_tog", toggle_state, 4'b1111);
        tick();

        // Clean step on channel 0, rise then fall.
        noisy = '0;
        do_reset();
        repeat (8) tick();
        noisy = 4'b0001;
        measure_latency("step_rise_latency", 4'b0001);
        check("step_rise_cond", conditioned, 4'b0001);
        tick();
        repeat (4) tick();
        hold(4'b0000, 10);
        check("step_fall_cond", conditioned, 4'b0000);

        // Glitch rejection on channel 1.
        hold(4'b0010, 3);
        hold(4'b0000, 8);
        check("glitch_rejected", conditioned, 4'b0000);
        hold(4'b0010, 3);
        hold(4'b0000, 1);
        hold(4'b0010, 12);
        check("glitch_then_accept", conditioned, 4'b0010);
        hold(4'b0000, 10);

        // Simultaneous opposite transitions.
        hold(4'b0101, 10);
        hold(4'b1010, 10);
        check("simultaneous_cond", conditioned, 4'b1010);
        hold(4'b0000, 10);

        // Toggle latch on channel 2.
        do_reset();
        repeat (8) tick();
        press(1'b0, 1'b1);
        press(1'b0, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);

        // Reset in the middle of a count on channel 3.
        hold(4'b0000, 4);
        noisy = 4'b1000;
        repeat (3) tick();
        do_reset();
        measure_latency("midcount_reset_latency", 4'b1000);
        tick();
        hold(4'b0000, 10);

        // Randomized phase: per-channel random hold lengths straddle the
        // acceptance threshold, with occasional clears and resets.
        for (int i = 0; i < CH; i++) hold_cnt[i] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < CH; i++) begin
                if (hold_cnt[i] == 0) begin
                    noisy[i]    = 1'($urandom_range(0, 1));
                    hold_cnt[i] = $urandom_range(1, 8);
                end else begin
                    hold_cnt[i]--;
                end
            end
            toggle_clr = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end
        toggle_clr = '0;
        hold(4'b0000, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
